game_flow_ctrl: RTL and testbench

//  Turn scheduler/sequencer for the Connect-4 board. Arbitrates move requests from player A and player B
//  (local buttons or remote link), validates them against per-column fill heights, and issues one panel write.

---
 rtl/score4_pkg.sv | 33 +++
 rtl/game_flow_ctrl_if.sv | 49 ++++
 rtl/game_flow_ctrl_move_timer.sv | 28 ++
 rtl/game_flow_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/score4_pkg.sv
// Shared types and board defaults for the Connect-4 turn sequencer.
// Optional build macro used by the consumers of this package: TURN_TIMEOUT_EN.
package score4_pkg;

  localparam int ROWS_DEFAULT        = 6;
  localparam int COLS_DEFAULT        = 7;
  localparam int CHECK_LAT_DEFAULT   = 2;
  localparam int TIMEOUT_CYC_DEFAULT = 50_000_000;

  localparam int COL_W = 3;
  localparam int ROW_W = 3;

  typedef logic [COL_W-1:0] col_t;
  typedef logic [ROW_W-1:0] row_t;

  typedef enum logic {
    PLAYER_A = 1'b0,
    PLAYER_B = 1'b1
  } player_t;

  typedef enum logic [2:0] {
    WAIT_MOVE = 3'd0,
    WRITE     = 3'd1,
    SETTLE    = 3'd2,
    EVAL      = 3'd3,
    OVER      = 3'd4
  } flow_state_t;

  function automatic logic col_in_range(input col_t c, input int cols);
    return int'(c) < cols;
  endfunction

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Bundle of move-request, checker and panel-write signals around game_flow_ctrl.
// The timeout pulse exists only when TURN_TIMEOUT_EN is defined.
interface game_flow_ctrl_if;
  import score4_pkg::*;

  logic    new_game;
  logic    req_a;
  col_t    col_a;
  logic    req_b;
  col_t    col_b;
  logic    win_a;
  logic    win_b;
  logic    full_in;

  logic    clr_panel;
  logic    wr_en;
  row_t    wr_row;
  col_t    wr_col;
  player_t wr_player;
  player_t turn;
  logic    busy;
  logic    invalid_move;
  logic    wrong_turn;
  logic    game_over;
  logic    [1:0] winner;
  logic    draw;
`ifdef TURN_TIMEOUT_EN
  logic    timeout;
`endif

  modport master (
    output new_game, req_a, col_a, req_b, col_b, win_a, win_b, full_in,
    input  clr_panel, wr_en, wr_row, wr_col, wr_player, turn, busy,
           invalid_move, wrong_turn, game_over, winner, draw
`ifdef TURN_TIMEOUT_EN
    , input timeout
`endif
  );

  modport slave (
    input  new_game, req_a, col_a, req_b, col_b, win_a, win_b, full_in,
    output clr_panel, wr_en, wr_row, wr_col, wr_player, turn, busy,
           invalid_move, wrong_turn, game_over, winner, draw
`ifdef TURN_TIMEOUT_EN
    , output timeout
`endif
  );

endinterface

// File: rtl/game_flow_ctrl_move_timer.sv
// Idle counter that forces a turn pass; only built when TURN_TIMEOUT_EN is defined.
`ifdef TURN_TIMEOUT_EN
module move_timer #(
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);

  logic [CW-1:0] r_cnt;

  assign o_expire = i_enable && !i_clear && (r_cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || i_clear || o_expire) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/game_flow_ctrl.sv
// Connect-4 turn sequencer: validates moves, issues one panel write, waits for the checker.
// Define TURN_TIMEOUT_EN to add the idle-turn timeout and its timeout pulse.
module game_flow_ctrl
  import score4_pkg::*;
#(
  parameter int ROWS        = ROWS_DEFAULT,
  parameter int COLS        = COLS_DEFAULT,
  parameter int CHECK_LAT   = CHECK_LAT_DEFAULT,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input logic             clk,
  input logic             rst,
  game_flow_ctrl_if.slave flow
);

  localparam logic [2:0] S_WAIT   = WAIT_MOVE;
  localparam logic [2:0] S_WRITE  = WRITE;
  localparam logic [2:0] S_SETTLE = SETTLE;
  localparam logic [2:0] S_EVAL   = EVAL;
  localparam logic [2:0] S_OVER   = OVER;
  localparam int         SW       = (CHECK_LAT < 2) ? 1 : $clog2(CHECK_LAT);

  logic [2:0]    r_state;
  row_t          r_height [COLS];
  col_t          r_col;
  player_t       r_turn;
  logic [SW-1:0] r_settle;
  logic          r_clr;
  logic          r_invalid;
  logic          r_wrong;
  logic          r_over;
  logic          r_draw;
  logic [1:0]    r_winner;

  // Columns beyond COLS have no height entry and read as empty.
  function automatic row_t height_of(input col_t c);
    row_t h;
    h = '0;
    for (int k = 0; k < COLS; k++) begin
      if (c == COL_W'(k)) h = r_height[k];
    end
    return h;
  endfunction

  function automatic player_t other(input player_t p);
    return (p == PLAYER_A) ? PLAYER_B : PLAYER_A;
  endfunction

  logic w_in_wait;
  logic w_req_on;
  logic w_req_off;
  col_t w_req_col;
  row_t w_req_h;
  logic w_col_ok;
  logic w_accept;
  logic w_reject;
  logic w_wrong;
  row_t w_wr_row;
  logic w_wr_ok;

  assign w_in_wait = (r_state == S_WAIT);
  assign w_req_on  = (r_turn == PLAYER_A) ? flow.req_a : flow.req_b;
  assign w_req_off = (r_turn == PLAYER_A) ? flow.req_b : flow.req_a;
  assign w_req_col = (r_turn == PLAYER_A) ? flow.col_a : flow.col_b;
  assign w_req_h   = height_of(w_req_col);
  assign w_col_ok  = col_in_range(w_req_col, COLS) && (int'(w_req_h) < ROWS);
  assign w_accept  = w_in_wait && w_req_on && w_col_ok;
  assign w_reject  = w_in_wait && w_req_on && !w_col_ok;
  assign w_wrong   = w_in_wait && w_req_off;
  assign w_wr_row  = height_of(r_col);
  assign w_wr_ok   = (r_state == S_WRITE) && (int'(w_wr_row) < ROWS);

`ifdef TURN_TIMEOUT_EN
  logic w_tmr_expire;
  logic r_timeout;

  move_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_move_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (!w_in_wait || flow.new_game),
    .i_enable (w_in_wait && !w_accept),
    .o_expire (w_tmr_expire)
  );

  assign flow.timeout = r_timeout;
`endif

  // Accepted column is plain data and needs no reset.
  always_ff @(posedge clk) begin
    if (w_accept && !flow.new_game) r_col <= w_req_col;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_WAIT;
      r_turn    <= PLAYER_A;
      r_settle  <= '0;
      r_clr     <= 1'b0;
      r_invalid <= 1'b0;
      r_wrong   <= 1'b0;
      r_over    <= 1'b0;
      r_draw    <= 1'b0;
      r_winner  <= 2'b00;
      for (int k = 0; k < COLS; k++) r_height[k] <= '0;
`ifdef TURN_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
    end else begin
      r_clr     <= 1'b0;
      r_invalid <= 1'b0;
      r_wrong   <= 1'b0;
`ifdef TURN_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
      if (flow.new_game) begin
        r_state  <= S_WAIT;
        r_turn   <= PLAYER_A;
        r_clr    <= 1'b1;
        r_over   <= 1'b0;
        r_draw   <= 1'b0;
        r_winner <= 2'b00;
        for (int k = 0; k < COLS; k++) r_height[k] <= '0;
      end else begin
        case (r_state)
          S_WAIT: begin
            r_invalid <= w_reject;
            r_wrong   <= w_wrong;
            if (w_accept) begin
              r_state <= S_WRITE;
            end
`ifdef TURN_TIMEOUT_EN
            else if (w_tmr_expire) begin
              r_turn    <= other(r_turn);
              r_timeout <= 1'b1;
            end
`endif
          end
          S_WRITE: begin
            for (int k = 0; k < COLS; k++) begin
              if (r_col == COL_W'(k) && int'(r_height[k]) < ROWS)
                r_height[k] <= r_height[k] + 1'b1;
            end
            r_settle <= '0;
            r_state  <= S_SETTLE;
          end
          S_SETTLE: begin
            if (r_settle == SW'(CHECK_LAT - 1)) r_state <= S_EVAL;
            else                                r_settle <= r_settle + 1'b1;
          end
          S_EVAL: begin
            if (flow.win_a || flow.win_b) begin
              r_winner <= {flow.win_b, flow.win_a};
              r_over   <= 1'b1;
              r_state  <= S_OVER;
            end else if (flow.full_in) begin
              r_draw  <= 1'b1;
              r_over  <= 1'b1;
              r_state <= S_OVER;
            end else begin
              r_turn  <= other(r_turn);
              r_state <= S_WAIT;
            end
          end
          S_OVER: begin
            r_state <= S_OVER;
          end
          default: begin
            r_state <= S_WAIT;
          end
        endcase
      end
    end
  end

  assign flow.clr_panel    = r_clr;
  assign flow.wr_en        = w_wr_ok;
  assign flow.wr_row       = w_wr_ok ? w_wr_row : '0;
  assign flow.wr_col       = w_wr_ok ? r_col : '0;
  assign flow.wr_player    = r_turn;
  assign flow.turn         = r_turn;
  assign flow.busy         = !w_in_wait;
  assign flow.invalid_move = r_invalid;
  assign flow.wrong_turn   = r_wrong;
  assign flow.game_over    = r_over;
  assign flow.winner       = r_winner;
  assign flow.draw         = r_draw;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: fixed vector table, hand-written corner sequences, random moves vs a board model.
module tb_game_flow_ctrl;

  localparam int ROWS      = 6;
  localparam int COLS      = 7;
  localparam int CHECK_LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  game_flow_ctrl_if bus ();

  game_flow_ctrl #(
    .ROWS      (ROWS),
    .COLS      (COLS),
    .CHECK_LAT (CHECK_LAT)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .flow (bus)
  );

  typedef struct {
    logic       ng;
    logic       ra;
    logic [2:0] ca;
    logic       rb;
    logic [2:0] cb;
    logic       wa;
    logic       wb;
    logic       fl;
    logic       e_wr;
    logic [2:0] e_row;
    logic       e_pl;
    logic       e_inv;
    logic       e_wrong;
    logic       e_turn;
    logic       e_over;
    logic [1:0] e_win;
    logic       e_draw;
  } vec_t;

  typedef struct {
    logic       wr;
    logic [2:0] row;
    logic [2:0] col;
    logic       pl;
    logic       inv;
    logic       wrong;
    logic       busy_mid;
    logic       pulse_after;
    logic       turn;
    logic       over;
    logic [1:0] winner;
    logic       draw;
    logic       busy;
  } obs_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Board model: column fill counts plus game status.
  int         m_h [COLS];
  logic       m_turn;
  logic       m_over;
  logic       m_draw;
  logic [1:0] m_win;

  vec_t tbl [19];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < COLS; k++) m_h[k] = 0;
    m_turn = 1'b0;
    m_over = 1'b0;
    m_draw = 1'b0;
    m_win  = 2'b00;
  endtask

  task automatic run_move(input logic ra, input logic [2:0] ca, input logic rb, input logic [2:0] cb,
                          input logic wa, input logic wb, input logic fl, output obs_t o);
    bus.req_a = ra; bus.col_a = ca; bus.req_b = rb; bus.col_b = cb;
    tick();
    bus.req_a = 1'b0; bus.req_b = 1'b0;
    o.wr = bus.wr_en; o.row = bus.wr_row; o.col = bus.wr_col; o.pl = bus.wr_player;
    o.inv = bus.invalid_move; o.wrong = bus.wrong_turn; o.busy_mid = 1'b0;
    if (bus.wr_en) begin
      repeat (CHECK_LAT) tick();
      o.busy_mid = bus.busy;
      bus.win_a = wa; bus.win_b = wb; bus.full_in = fl;
      tick();
      tick();
      bus.win_a = 1'b0; bus.win_b = 1'b0; bus.full_in = 1'b0;
    end else begin
      tick();
    end
    o.pulse_after = bus.invalid_move | bus.wrong_turn | bus.wr_en;
    o.turn = bus.turn; o.over = bus.game_over; o.winner = bus.winner;
    o.draw = bus.draw; o.busy = bus.busy;
  endtask

  task automatic cmp(input string tag, input obs_t g, input obs_t e);
    chk({tag, " wr_en"}, g.wr, e.wr);
    chk({tag, " invalid_move"}, g.inv, e.inv);
    chk({tag, " wrong_turn"}, g.wrong, e.wrong);
    chk({tag, " pulse_drop"}, g.pulse_after, 0);
    chk({tag, " turn"}, g.turn, e.turn);
    chk({tag, " game_over"}, g.over, e.over);
    chk({tag, " winner"}, g.winner, e.winner);
    chk({tag, " draw"}, g.draw, e.draw);
    chk({tag, " busy"}, g.busy, e.busy);
    if (e.wr) begin
      chk({tag, " wr_row"}, g.row, e.row);
      chk({tag, " wr_col"}, g.col, e.col);
      chk({tag, " wr_player"}, g.pl, e.pl);
      chk({tag, " busy_settle"}, g.busy_mid, 1);
    end
  endtask

  task automatic do_new_game(input string tag);
    bus.new_game = 1'b1;
    tick();
    bus.new_game = 1'b0;
    chk({tag, " clr_panel"}, bus.clr_panel, 1);
    chk({tag, " ng turn"}, bus.turn, 0);
    chk({tag, " ng game_over"}, bus.game_over, 0);
    chk({tag, " ng winner"}, bus.winner, 0);
    chk({tag, " ng draw"}, bus.draw, 0);
    chk({tag, " ng busy"}, bus.busy, 0);
    tick();
    chk({tag, " clr_panel drop"}, bus.clr_panel, 0);
    model_clear();
  endtask

  // Expected outcome of one request derived from the game rules and the board model.
  task automatic model_move(input logic ra, input logic [2:0] ca, input logic rb, input logic [2:0] cb,
                            input logic wa, input logic wb, input logic fl, output obs_t e);
    logic on, off, valid;
    int   c;
    e = '{default: 1'b0};
    if (!m_over) begin
      on  = m_turn ? rb : ra;
      off = m_turn ? ra : rb;
      c   = m_turn ? int'(cb) : int'(ca);
      valid = on && (c < COLS) && (m_h[c] < ROWS);
      e.wr    = valid;
      e.inv   = on && !valid;
      e.wrong = off;
      e.pl    = m_turn;
      e.col   = 3'(c);
      if (valid) begin
        e.row  = 3'(m_h[c]);
        m_h[c] = m_h[c] + 1;
        if (wa || wb) begin
          m_over = 1'b1;
          m_win  = {wb, wa};
        end else if (fl) begin
          m_over = 1'b1;
          m_draw = 1'b1;
        end else begin
          m_turn = ~m_turn;
        end
      end
    end
    e.turn = m_turn; e.over = m_over; e.winner = m_win; e.draw = m_draw; e.busy = m_over;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t o, e;
    bus.new_game = 1'b0; bus.req_a = 1'b0; bus.col_a = '0; bus.req_b = 1'b0; bus.col_b = '0;
    bus.win_a = 1'b0; bus.win_b = 1'b0; bus.full_in = 1'b0;
    model_clear();

    //        ng ra ca rb cb wa wb fl | wr row pl inv wrg | turn over win draw
    tbl[0]  = '{0, 0, 3'd0, 1, 3'd2, 0, 0, 0, 0, 3'd0, 0, 0, 1, 0, 0, 2'b00, 0};
    tbl[1]  = '{0, 1, 3'd3, 0, 3'd0, 0, 0, 0, 1, 3'd0, 0, 0, 0, 1, 0, 2'b00, 0};
    tbl[2]  = '{0, 0, 3'd0, 1, 3'd0, 0, 0, 0, 1, 3'd0, 1, 0, 0, 0, 0, 2'b00, 0};
    tbl[3]  = '{0, 1, 3'd0, 0, 3'd0, 0, 0, 0, 1, 3'd1, 0, 0, 0, 1, 0, 2'b00, 0};
    tbl[4]  = '{0, 0, 3'd0, 1, 3'd0, 0, 0, 0, 1, 3'd2, 1, 0, 0, 0, 0, 2'b00, 0};
    tbl[5]  = '{0, 1, 3'd0, 0, 3'd0, 0, 0, 0, 1, 3'd3, 0, 0, 0, 1, 0, 2'b00, 0};
    tbl[6]  = '{0, 0, 3'd0, 1, 3'd0, 0, 0, 0, 1, 3'd4, 1, 0, 0, 0, 0, 2'b00, 0};
    tbl[7]  = '{0, 1, 3'd0, 0, 3'd0, 0, 0, 0, 1, 3'd5, 0, 0, 0, 1, 0, 2'b00, 0};
    tbl[8]  = '{0, 0, 3'd0, 1, 3'd0, 0, 0, 0, 0, 3'd0, 0, 1, 0, 1, 0, 2'b00, 0};
    tbl[9]  = '{0, 0, 3'd0, 1, 3'd7, 0, 0, 0, 0, 3'd0, 0, 1, 0, 1, 0, 2'b00, 0};
    tbl[10] = '{0, 0, 3'd0, 1, 3'd6, 0, 0, 0, 1, 3'd0, 1, 0, 0, 0, 0, 2'b00, 0};
    tbl[11] = '{0, 1, 3'd7, 0, 3'd0, 0, 0, 0, 0, 3'd0, 0, 1, 0, 0, 0, 2'b00, 0};
    tbl[12] = '{0, 1, 3'd1, 1, 3'd4, 0, 0, 0, 1, 3'd0, 0, 0, 1, 1, 0, 2'b00, 0};
    tbl[13] = '{0, 0, 3'd0, 1, 3'd5, 0, 1, 0, 1, 3'd0, 1, 0, 0, 1, 1, 2'b10, 0};
    tbl[14] = '{0, 1, 3'd2, 0, 3'd0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 1, 1, 2'b10, 0};
    tbl[15] = '{0, 0, 3'd0, 1, 3'd2, 0, 0, 0, 0, 3'd0, 0, 0, 0, 1, 1, 2'b10, 0};
    tbl[16] = '{1, 1, 3'd3, 0, 3'd0, 0, 0, 0, 1, 3'd0, 0, 0, 0, 1, 0, 2'b00, 0};
    tbl[17] = '{0, 0, 3'd0, 1, 3'd3, 0, 0, 1, 1, 3'd1, 1, 0, 0, 1, 1, 2'b00, 1};
    tbl[18] = '{1, 1, 3'd0, 0, 3'd0, 1, 0, 0, 1, 3'd0, 0, 0, 0, 0, 1, 2'b01, 0};

    repeat (3) tick();
    rst = 1'b0;
    chk("reset turn", bus.turn, 0);
    chk("reset busy", bus.busy, 0);
    chk("reset game_over", bus.game_over, 0);
    chk("reset winner", bus.winner, 0);
    chk("reset draw", bus.draw, 0);
    chk("reset clr_panel", bus.clr_panel, 0);
    chk("reset wr_en", bus.wr_en, 0);
    chk("reset pulses", {bus.invalid_move, bus.wrong_turn}, 0);

    for (int i = 0; i < 19; i++) begin
      if (tbl[i].ng) do_new_game($sformatf("v%0d", i));
      run_move(tbl[i].ra, tbl[i].ca, tbl[i].rb, tbl[i].cb, tbl[i].wa, tbl[i].wb, tbl[i].fl, o);
      e.wr = tbl[i].e_wr; e.row = tbl[i].e_row; e.pl = tbl[i].e_pl;
      e.col = tbl[i].e_pl ? tbl[i].cb : tbl[i].ca;
      e.inv = tbl[i].e_inv; e.wrong = tbl[i].e_wrong; e.busy_mid = tbl[i].e_wr; e.pulse_after = 1'b0;
      e.turn = tbl[i].e_turn; e.over = tbl[i].e_over; e.winner = tbl[i].e_win;
      e.draw = tbl[i].e_draw; e.busy = tbl[i].e_over;
      cmp($sformatf("v%0d", i), o, e);
    end

    // new_game during SETTLE with a pending win must discard the move.
    do_new_game("h1");
    bus.req_a = 1'b1; bus.col_a = 3'd4;
    tick();
    bus.req_a = 1'b0;
    chk("h1 wr_en", bus.wr_en, 1);
    tick();
    bus.win_a = 1'b1; bus.new_game = 1'b1;
    tick();
    bus.new_game = 1'b0;
    chk("h1 clr_panel", bus.clr_panel, 1);
    chk("h1 busy", bus.busy, 0);
    repeat (4) tick();
    bus.win_a = 1'b0;
    chk("h1 game_over", bus.game_over, 0);
    chk("h1 turn", bus.turn, 0);
    chk("h1 busy idle", bus.busy, 0);
    run_move(1'b1, 3'd4, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, o);
    chk("h1 height cleared wr_en", o.wr, 1);
    chk("h1 height cleared row", o.row, 0);

    // Held off-turn request is taken at the earliest legal cycle.
    do_new_game("h2");
    begin
      int lat = 0;
      int nwrong = 0;
      logic found = 1'b0;
      bus.req_a = 1'b1; bus.col_a = 3'd5;
      tick();
      bus.req_a = 1'b0;
      chk("h2 first wr_en", bus.wr_en, 1);
      bus.req_b = 1'b1; bus.col_b = 3'd5;
      for (int k = 0; k < 20 && !found; k++) begin
        tick();
        lat++;
        if (bus.wrong_turn) nwrong++;
        if (bus.wr_en) begin
          found = 1'b1;
          chk("h2 second wr_row", bus.wr_row, 1);
          chk("h2 second wr_player", bus.wr_player, 1);
        end
      end
      bus.req_b = 1'b0;
      chk("h2 accept latency", lat, 2 + CHECK_LAT + 1);
      chk("h2 no wrong_turn", nwrong, 0);
      repeat (CHECK_LAT + 2) tick();
      chk("h2 turn back to A", bus.turn, 0);
      chk("h2 busy", bus.busy, 0);
    end

    do_new_game("rnd");
    for (int i = 0; i < 300; i++) begin
      logic ra, rb, wa, wb, fl;
      logic [2:0] ca, cb;
      int mode, ev;
      if (($urandom_range(0, 39) == 0) || (m_over && $urandom_range(0, 1) == 0)) begin
        do_new_game($sformatf("r%0d", i));
      end
      mode = $urandom_range(0, 5);
      ra = (mode == 0) || (mode == 2) || (mode == 4);
      rb = (mode == 1) || (mode == 2) || (mode == 5);
      ca = $urandom_range(0, 1) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      cb = $urandom_range(0, 1) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      ev = $urandom_range(0, 39);
      wa = (ev == 0); wb = (ev == 1); fl = (ev == 2);
      model_move(ra, ca, rb, cb, wa, wb, fl, e);
      run_move(ra, ca, rb, cb, wa, wb, fl, o);
      cmp($sformatf("r%0d", i), o, e);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
